// File: rtl/counter_poll_master.sv
// Avalon-MM poll master: periodically reads an 8-bit input PIO and republishes
// the sampled value with a change pulse, valid flag and bus-timeout status.
module counter_poll_master #(
   parameter int         POLL_DIV     = 50000,
   parameter logic [1:0] SLAVE_ADDR   = 2'd0,
   parameter int         READ_LATENCY = 1,
   parameter int         TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        poll_now,
   input  logic        clear_err,
   output logic [1:0]  avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic [7:0]  value,
   output logic        value_valid,
   output logic        changed,
   output logic        timeout_err,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DATA, S_CAPTURE} state_t;

   localparam logic [15:0] TMR_RELOAD = 16'(POLL_DIV - 1);
   localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);
   localparam logic [1:0]  LAT_LAST   = 2'(READ_LATENCY);

   state_t      r_state, w_next;
   logic [15:0] r_timer;
   logic [15:0] r_wait;
   logic [1:0]  r_lat;
   logic [7:0]  r_sample;
   logic [7:0]  r_value;
   logic        r_valid, r_changed, r_err, r_read;
   logic        w_launch, w_accept, w_timeout, w_sample;
   logic        w_unused_rd;

   // Upper readdata bits carry nothing for an 8-bit PIO.
   assign w_unused_rd = ^avm_readdata[31:8];

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic and the per-state event strobes used by the datapath.
   always_comb begin
      w_next    = r_state;
      w_launch  = 1'b0;
      w_accept  = 1'b0;
      w_timeout = 1'b0;
      w_sample  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // With enable low the timer freezes and poll_now is ignored.
            if (enable && (r_timer == 16'd0 || poll_now)) begin
               w_next   = S_REQ;
               w_launch = 1'b1;
            end
         end
         S_REQ: begin
            if (!avm_waitrequest) begin
               w_next   = S_WAIT_DATA;
               w_accept = 1'b1;
            end else if (r_wait == WAIT_LAST) begin
               // This is the TIMEOUT-th stalled cycle: abandon the read.
               w_next    = S_IDLE;
               w_timeout = 1'b1;
            end
         end
         S_WAIT_DATA: begin
            if (r_lat == LAT_LAST) begin
               w_next   = S_CAPTURE;
               w_sample = 1'b1;
            end
         end
         S_CAPTURE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Poll timer, bus request, wait/latency counters, capture and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timer   <= TMR_RELOAD;
         r_wait    <= 16'd0;
         r_lat     <= 2'd1;
         r_read    <= 1'b0;
         r_sample  <= 8'd0;
         r_value   <= 8'd0;
         r_valid   <= 1'b0;
         r_changed <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_launch)
            r_timer <= TMR_RELOAD;
         else if (r_state == S_IDLE && enable)
            r_timer <= r_timer - 16'd1;

         if (w_launch)                    r_read <= 1'b1;
         else if (w_accept || w_timeout)  r_read <= 1'b0;

         if (w_launch)
            r_wait <= 16'd0;
         else if (r_state == S_REQ && avm_waitrequest)
            r_wait <= r_wait + 16'd1;

         if (w_accept)                    r_lat <= 2'd1;
         else if (r_state == S_WAIT_DATA) r_lat <= r_lat + 2'd1;

         if (w_sample) r_sample <= avm_readdata[7:0];

         // changed is aligned with the cycle the new value becomes visible.
         r_changed <= (r_state == S_CAPTURE) && r_valid && (r_sample != r_value);
         if (r_state == S_CAPTURE) begin
            r_value <= r_sample;
            r_valid <= 1'b1;
         end

         // A timeout in the same cycle as clear_err wins.
         if (w_timeout)      r_err <= 1'b1;
         else if (clear_err) r_err <= 1'b0;
      end
   end

   assign avm_address = SLAVE_ADDR;
   assign avm_read    = r_read;
   assign value       = r_value;
   assign value_valid = r_valid;
   assign changed     = r_changed;
   assign timeout_err = r_err;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_counter_poll_master.sv
// Bench for counter_poll_master: behavioural PIO slave with programmable
// stall, scoreboard of expected captures keyed by due cycle, vector table.
module tb_counter_poll_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0, poll_now = 1'b0, clear_err = 1'b0;
   logic [1:0]  avm_address;
   logic        avm_read, avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [7:0]  value;
   logic        value_valid, changed, timeout_err, busy;

   counter_poll_master #(.POLL_DIV(8), .SLAVE_ADDR(2'd0), .READ_LATENCY(1), .TIMEOUT(255)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .poll_now(poll_now),
      .clear_err(clear_err), .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .value(value), .value_valid(value_valid), .changed(changed),
      .timeout_err(timeout_err), .busy(busy));

   always #5 clk = ~clk;

   typedef struct { int due; logic [7:0] v; logic c; } sb_t;
   typedef struct { logic [7:0] sv; int stall; logic [7:0] ev; logic ec; } vec_t;

   sb_t  sb[$];
   int   n_vec = 0, n_err = 0;
   int   cyc = 0;
   int   n_acc = 0;

   // Slave model state driven by the stimulus process.
   logic [7:0]  slave_val = 8'h00;
   int          stall_req = 0;
   logic        stuck = 1'b0;
   logic [7:0]  exp_v = 8'h00;
   logic        exp_c = 1'b0;
   int          st = 0;
   logic [31:0] rd_q = 32'h0;

   assign avm_waitrequest = stuck | (avm_read && (st < stall_req));
   assign avm_readdata    = rd_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // PIO slave: registered readdata one cycle after acceptance, junk in 31:8.
   always @(posedge clk) begin
      if (!avm_read) st <= 0;
      else if (avm_waitrequest) st <= st + 1;
      if (avm_read && !avm_waitrequest) begin
         rd_q  <= {24'hC3A5F0, slave_val};
         n_acc <= n_acc + 1;
         sb.push_back('{due: cyc + 3, v: exp_v, c: exp_c});
      end
   end

   // Scoreboard: compare a capture when it falls due; otherwise changed must stay low.
   always @(negedge clk) begin
      sb_t e;
      if (reset_n) begin
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("sb_value", 32'(value), 32'(e.v));
            chk("sb_valid", 32'(value_valid), 32'd1);
            chk("sb_changed", 32'(changed), 32'(e.c));
         end else begin
            chk("changed_idle", 32'(changed), 32'd0);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      chk("idle", 32'(busy), 32'd0);
   endtask

   // Idle tail: no read may start (catches a latched poll_now).
   task automatic quiet_tail();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("no_extra_read", 32'(avm_read), 32'd0);
      end
   endtask

   // Launch a poll with poll_now, optionally re-pulsing poll_now mid-transfer.
   task automatic do_poll(input vec_t v, input bit dup);
      int len = 0;
      @(negedge clk);
      slave_val = v.sv; stall_req = v.stall; exp_v = v.ev; exp_c = v.ec;
      poll_now = 1'b1;
      @(negedge clk);
      poll_now = 1'b0;
      chk("read_start", 32'(avm_read), 32'd1);
      while (avm_read === 1'b1 && len < 400) begin
         chk("addr_stable", 32'(avm_address), 32'd0);
         poll_now = (dup && len == 1);
         len++;
         @(negedge clk);
      end
      poll_now = 1'b0;
      chk("read_len", 32'(len), 32'(v.stall + 1));
      wait_idle();
      quiet_tail();
      chk("no_timeout", 32'(timeout_err), 32'd0);
   endtask

   initial begin
      vec_t tbl[7];
      int   n, len, a0;
      tbl[0] = '{sv: 8'h5A, stall: 0, ev: 8'h5A, ec: 1'b0};
      tbl[1] = '{sv: 8'h5B, stall: 0, ev: 8'h5B, ec: 1'b1};
      tbl[2] = '{sv: 8'h5B, stall: 0, ev: 8'h5B, ec: 1'b0};
      tbl[3] = '{sv: 8'h5C, stall: 3, ev: 8'h5C, ec: 1'b1};
      tbl[4] = '{sv: 8'hFF, stall: 1, ev: 8'hFF, ec: 1'b1};
      tbl[5] = '{sv: 8'hFF, stall: 0, ev: 8'hFF, ec: 1'b0};
      tbl[6] = '{sv: 8'h00, stall: 2, ev: 8'h00, ec: 1'b1};

      // Reset state.
      enable = 1'b1;
      slave_val = tbl[0].sv; exp_v = tbl[0].ev; exp_c = tbl[0].ec;
      repeat (3) @(negedge clk);
      chk("rst_read", 32'(avm_read), 32'd0);
      chk("rst_addr", 32'(avm_address), 32'd0);
      chk("rst_value", 32'(value), 32'd0);
      chk("rst_valid", 32'(value_valid), 32'd0);
      chk("rst_changed", 32'(changed), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Timer-driven first poll: read seen 8 cycles after release.
      reset_n = 1'b1;
      n = 0;
      while (avm_read !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("first_read_delay", 32'(n), 32'd8);
      wait_idle();
      quiet_tail();

      // Vector table, poll_now driven; vector 3 also re-pulses poll_now while busy.
      for (int i = 1; i < 7; i++) do_poll(tbl[i], i == 3);

      // enable=0: timer frozen and poll_now ignored.
      @(negedge clk);
      enable = 1'b0; a0 = n_acc;
      poll_now = 1'b1; @(negedge clk); poll_now = 1'b0;
      repeat (20) @(negedge clk);
      chk("dis_no_read", 32'(n_acc - a0), 32'd0);
      chk("dis_busy", 32'(busy), 32'd0);
      enable = 1'b1;

      // Stuck waitrequest, clear_err held through the timeout cycle.
      @(negedge clk);
      stuck = 1'b1; clear_err = 1'b1; poll_now = 1'b1;
      @(negedge clk);
      poll_now = 1'b0;
      len = 0;
      while (avm_read === 1'b1 && len < 400) begin len++; @(negedge clk); end
      clear_err = 1'b0;
      chk("to_len", 32'(len), 32'd255);
      chk("to_err_set", 32'(timeout_err), 32'd1);
      chk("to_value_kept", 32'(value), 32'h00);
      chk("to_busy", 32'(busy), 32'd0);
      stuck = 1'b0;
      @(negedge clk); clear_err = 1'b1;
      @(negedge clk); clear_err = 1'b0;
      chk("to_err_clr", 32'(timeout_err), 32'd0);

      // Reset asserted during WAIT_DATA.
      do_poll('{sv: 8'h5A, stall: 0, ev: 8'h5A, ec: 1'b1}, 1'b0);
      @(negedge clk);
      slave_val = 8'h77; stall_req = 0; exp_v = 8'h77; exp_c = 1'b0;
      poll_now = 1'b1;
      @(negedge clk); poll_now = 1'b0;
      @(negedge clk);
      chk("wd_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      sb.delete();
      chk("arst_value", 32'(value), 32'd0);
      chk("arst_valid", 32'(value_valid), 32'd0);
      chk("arst_read", 32'(avm_read), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_err", 32'(timeout_err), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      while (avm_read !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk("post_rst_delay", 32'(n), 32'd8);
      wait_idle();
      quiet_tail();
      chk("post_rst_value", 32'(value), 32'h77);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
